// File: rtl/orb_pkg.sv
// Shared constants for the ORB frame-buffer write scheduler: parameter defaults,
// FSM state encoding and the RAM word packing helper.
package orb_pkg;

  localparam int NCH_DEF    = 5;
  localparam int WPC_DEF    = 6;
  localparam int WE_LEN_DEF = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // A channel byte sits in the middle of the 12-bit RAM word.
  function automatic logic [11:0] packWord(input logic [7:0] b);
    return {1'b0, b, 3'b000};
  endfunction

endpackage

// File: rtl/orb_rr_arb.sv
// Round-robin arbiter: the channel at index ptr has highest priority,
// followed by ptr+1, ptr+2, ... wrapping at NCH.
module orb_rr_arb #(
  parameter int NCH = 5,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gntIdx
);

  int   idx;
  logic found;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gntIdx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/orb_wr_scheduler.sv
// Collects bytes from NCH asynchronous receiver channels and serialises them
// onto one frame-buffer write port, packet by packet, with page-toggle support.
module orb_wr_scheduler
  import orb_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int WPC    = WPC_DEF,
  parameter int WE_LEN = WE_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   strob,
  input  logic [8*NCH-1:0] iData,
  input  logic             sw,
  output logic [11:0]      orbWord,
  output logic [10:0]      WrAddr,
  output logic             WE,
  output logic             busy,
  output logic [NCH-1:0]   overrun,
  output logic             frame_done,
  output logic             swap_ack
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(WPC + 1);
  localparam int LW = (WE_LEN > 1) ? $clog2(WE_LEN) : 1;

  logic [NCH-1:0] strobS1, strobS2, strobOld, byteEv;
  logic           swS1, swS2, swOld, swToggle, swAckD;
  logic [7:0]     holdData [NCH];
  logic [CW-1:0]  wcnt [NCH];
  logic [NCH-1:0] pend, full, req, gnt;
  logic [5:0]     pack;
  logic [1:0]     state;
  logic [LW-1:0]  weCnt;
  logic [IW-1:0]  curCh, rrPtr, gntIdx;
  logic [4:0]     slot;
  logic           grantNow, advance;

  orb_rr_arb #(.NCH(NCH), .IW(IW)) uArb (
    .req    (req),
    .ptr    (rrPtr),
    .gnt    (gnt),
    .gntIdx (gntIdx)
  );

  always_comb begin
    for (int k = 0; k < NCH; k++) full[k] = (wcnt[k] == CW'(WPC));
    req      = pend & ~full;
    byteEv   = strobS2 & ~strobOld;
    swToggle = swS2 ^ swOld;
    grantNow = (state == ST_IDLE) && (|req) && !swToggle;
    advance  = (&full) && !swToggle;
    slot     = 5'(int'(gntIdx) * WPC + int'(wcnt[gntIdx]));
  end

  assign WE   = (state == ST_WRITE);
  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {strobS1, strobS2, strobOld} <= '0;
      {swS1, swS2, swOld}          <= '0;
    end else begin
      strobS1  <= strob;
      strobS2  <= strobS1;
      strobOld <= strobS2;
      swS1     <= sw;
      swS2     <= swS1;
      swOld    <= swS2;
    end
  end

  // NOTE: the byte holding registers are pure data storage qualified by pend, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++)
      if (byteEv[k] && !full[k]) holdData[k] <= iData[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      weCnt      <= '0;
      curCh      <= '0;
      rrPtr      <= '0;
      pend       <= '0;
      pack       <= '0;
      overrun    <= '0;
      orbWord    <= '0;
      WrAddr     <= '0;
      frame_done <= 1'b0;
      swAckD     <= 1'b0;
      swap_ack   <= 1'b0;
      for (int k = 0; k < NCH; k++) wcnt[k] <= '0;
    end else begin
      frame_done <= 1'b0;
      swAckD     <= swToggle;
      swap_ack   <= swAckD;

      if (swToggle) begin
        // Page toggle wins over everything else in this cycle; overrun is kept.
        state <= ST_IDLE;
        pack  <= '0;
        pend  <= '0;
        for (int k = 0; k < NCH; k++) wcnt[k] <= '0;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (byteEv[k]) begin
            if (full[k]) begin
              overrun[k] <= 1'b1;
            end else begin
              // A byte arriving as its channel is granted is a fresh byte, not a loss.
              if (pend[k] && !(grantNow && gnt[k])) overrun[k] <= 1'b1;
              pend[k] <= 1'b1;
            end
          end else if (grantNow && gnt[k]) begin
            pend[k] <= 1'b0;
          end
        end

        if (advance) begin
          pack <= pack + 6'd1;
          if (pack == 6'd63) frame_done <= 1'b1;
          for (int k = 0; k < NCH; k++) wcnt[k] <= '0;
        end

        case (state)
          ST_IDLE: begin
            if (grantNow) begin
              curCh   <= gntIdx;
              rrPtr   <= (int'(gntIdx) == NCH - 1) ? '0 : gntIdx + 1'b1;
              orbWord <= packWord(holdData[gntIdx]);
              WrAddr  <= {pack, slot};
              state   <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            weCnt <= '0;
            state <= ST_WRITE;
          end
          ST_WRITE: begin
            if (weCnt == LW'(WE_LEN - 1)) begin
              wcnt[curCh] <= wcnt[curCh] + 1'b1;
              state       <= ST_GAP;
            end else begin
              weCnt <= weCnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_orb_wr_scheduler.sv
// Directed self-checking bench for orb_wr_scheduler with default parameters.
module tb_orb_wr_scheduler;

  localparam int NCH    = 5;
  localparam int WPC    = 6;
  localparam int WE_LEN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  strob;
  logic [39:0] iData;
  logic        sw;
  logic [11:0] orbWord;
  logic [10:0] WrAddr;
  logic        WE, busy, frame_done, swap_ack;
  logic [4:0]  overrun;

  int checks = 0;
  int errors = 0;

  logic [11:0] wordQ[$];
  logic [10:0] addrQ[$];
  int          widthQ[$];
  int          wrCount = 0;
  int          fdCount = 0;
  int          ackCount = 0;
  int          weRun = 0;
  logic        weQ = 1'b0;

  orb_wr_scheduler #(.NCH(NCH), .WPC(WPC), .WE_LEN(WE_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .strob      (strob),
    .iData      (iData),
    .sw         (sw),
    .orbWord    (orbWord),
    .WrAddr     (WrAddr),
    .WE         (WE),
    .busy       (busy),
    .overrun    (overrun),
    .frame_done (frame_done),
    .swap_ack   (swap_ack)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (WE === 1'b1 && !weQ) begin
      wordQ.push_back(orbWord);
      addrQ.push_back(WrAddr);
      wrCount++;
      weRun = 1;
    end else if (WE === 1'b1) begin
      weRun++;
    end else if (weQ) begin
      widthQ.push_back(weRun);
    end
    weQ = (WE === 1'b1);
    if (frame_done === 1'b1) fdCount++;
    if (swap_ack === 1'b1) ackCount++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0; strob = '0; iData = '0; sw = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    wordQ.delete(); addrQ.delete(); widthQ.delete();
    wrCount = 0; fdCount = 0; ackCount = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [4:0] mask, input logic [39:0] data);
    @(negedge clk);
    iData = data;
    strob = mask;
    repeat (3) @(negedge clk);
    strob = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (wrCount < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (wrCount < n) begin
      errors++;
      $display("FAIL write_timeout: got %0d writes expected %0d", wrCount, n);
    end
  endtask

  task automatic burst(input logic [4:0] mask, input logic [39:0] data);
    int target = wrCount + $countones(mask);
    pulse(mask, data);
    wait_writes(target, 400);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; strob = '0; iData = '0; sw = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (WE !== 1'b0)         begin errors++; $display("FAIL reset_we: got %b expected 0", WE); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (orbWord !== 12'h0)   begin errors++; $display("FAIL reset_word: got %h expected 000", orbWord); end
    checks++; if (WrAddr !== 11'h0)    begin errors++; $display("FAIL reset_addr: got %h expected 000", WrAddr); end
    checks++; if (overrun !== 5'h0)    begin errors++; $display("FAIL reset_overrun: got %b expected 00000", overrun); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (swap_ack !== 1'b0)   begin errors++; $display("FAIL reset_swap_ack: got %b expected 0", swap_ack); end
  endtask

  task automatic test_single_byte();
    logic [11:0] w;
    logic [10:0] a;
    int          wd;
    do_reset();
    pulse(5'b00001, 40'hA5);
    wait_writes(1, 100);
    repeat (4) @(negedge clk);
    w  = (wordQ.size() > 0) ? wordQ[0] : 12'hxxx;
    a  = (addrQ.size() > 0) ? addrQ[0] : 11'hxxx;
    wd = (widthQ.size() > 0) ? widthQ[0] : -1;
    checks++; if (w !== 12'h528)       begin errors++; $display("FAIL single_word: got %h expected 528", w); end
    checks++; if (a !== 11'h0)         begin errors++; $display("FAIL single_addr: got %0d expected 0", a); end
    checks++; if (wd != WE_LEN)        begin errors++; $display("FAIL single_we_width: got %0d expected %0d", wd, WE_LEN); end
    checks++; if (wrCount != 1)        begin errors++; $display("FAIL single_count: got %0d expected 1", wrCount); end
  endtask

  task automatic test_simultaneous();
    logic [7:0]  b;
    logic [11:0] w;
    logic [10:0] a;
    do_reset();
    pulse(5'b11111, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    wait_writes(5, 200);
    repeat (6) @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      b = 8'(17 * (i + 1));
      w = (wordQ.size() > i) ? wordQ[i] : 12'hxxx;
      a = (addrQ.size() > i) ? addrQ[i] : 11'hxxx;
      checks++; if (a !== 11'(i * WPC))       begin errors++; $display("FAIL simul_addr%0d: got %0d expected %0d", i, a, i * WPC); end
      checks++; if (w !== {1'b0, b, 3'b000})  begin errors++; $display("FAIL simul_word%0d: got %h expected %h", i, w, {1'b0, b, 3'b000}); end
    end
    checks++; if (overrun !== 5'h0) begin errors++; $display("FAIL simul_overrun: got %b expected 00000", overrun); end
  endtask

  task automatic test_overrun();
    logic [11:0] w;
    logic [10:0] a;
    do_reset();
    @(negedge clk);
    iData = {8'h55, 8'h44, 8'h3C, 8'h22, 8'h11};
    strob = 5'b11111;
    repeat (3) @(negedge clk);
    strob = '0;
    repeat (3) @(negedge clk);
    iData[23:16] = 8'hC3;
    strob = 5'b00100;
    repeat (3) @(negedge clk);
    strob = '0;
    wait_writes(5, 300);
    repeat (12) @(negedge clk);
    w = (wordQ.size() > 2) ? wordQ[2] : 12'hxxx;
    a = (addrQ.size() > 2) ? addrQ[2] : 11'hxxx;
    checks++; if (overrun !== 5'b00100) begin errors++; $display("FAIL ovr_flag: got %b expected 00100", overrun); end
    checks++; if (a !== 11'd12)         begin errors++; $display("FAIL ovr_addr: got %0d expected 12", a); end
    checks++; if (w !== 12'h618)        begin errors++; $display("FAIL ovr_word: got %h expected 618", w); end
    checks++; if (wrCount != 5)         begin errors++; $display("FAIL ovr_count: got %0d expected 5", wrCount); end
  endtask

  task automatic test_packet_advance();
    logic [10:0] a;
    do_reset();
    for (int r = 0; r < 6; r++) burst(5'b11111, {5{8'(r + 1)}});
    burst(5'b00010, 40'h77_00);
    a = addrQ[$];
    checks++; if (a !== 11'd38)          begin errors++; $display("FAIL pkt_addr: got %0d expected 38", a); end
    checks++; if (wordQ[$] !== 12'h3B8)  begin errors++; $display("FAIL pkt_word: got %h expected 3b8", wordQ[$]); end
    for (int r = 0; r < 5; r++) burst(5'b11111, {5{8'(r + 9)}});
    burst(5'b11101, {5{8'h0F}});
    for (int p = 2; p < 63; p++)
      for (int r = 0; r < 6; r++) burst(5'b11111, {5{8'(p)}});
    checks++; if (fdCount != 0) begin errors++; $display("FAIL pkt_fd_early: got %0d expected 0", fdCount); end
    for (int r = 0; r < 6; r++) burst(5'b11111, {5{8'h63}});
    repeat (4) @(negedge clk);
    checks++; if (fdCount != 1) begin errors++; $display("FAIL pkt_fd_wrap: got %0d expected 1", fdCount); end
    burst(5'b00001, 40'h81);
    checks++; if (addrQ[$] !== 11'd0) begin errors++; $display("FAIL pkt_wrap_addr: got %0d expected 0", addrQ[$]); end
    checks++; if (overrun !== 5'h0)   begin errors++; $display("FAIL pkt_overrun: got %b expected 00000", overrun); end
  endtask

  task automatic test_swap();
    int c;
    do_reset();
    burst(5'b00001, 40'h12);
    burst(5'b01000, 40'h34_000000);
    @(negedge clk);
    iData = 40'h9E_000000;
    strob = 5'b01000;
    c = 0;
    while (WE !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    checks++; if (WE !== 1'b1) begin errors++; $display("FAIL swap_we_start: got %b expected 1", WE); end
    sw = 1'b1;
    c = 0;
    while (WE === 1'b1 && c < 8) begin @(negedge clk); c++; end
    checks++; if (c > 4) begin errors++; $display("FAIL swap_we_drop: got %0d cycles expected <=4", c); end
    strob = '0;
    c = 0;
    while (ackCount == 0 && c < 20) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    checks++; if (ackCount != 1) begin errors++; $display("FAIL swap_ack: got %0d pulses expected 1", ackCount); end
    burst(5'b01000, 40'h5A_000000);
    checks++; if (addrQ[$] !== 11'd18)  begin errors++; $display("FAIL swap_addr: got %0d expected 18", addrQ[$]); end
    checks++; if (wordQ[$] !== 12'h2D0) begin errors++; $display("FAIL swap_word: got %h expected 2d0", wordQ[$]); end
    checks++; if (overrun !== 5'h0)     begin errors++; $display("FAIL swap_overrun: got %b expected 00000", overrun); end
  endtask

  task automatic test_async_reset();
    int c = 0;
    do_reset();
    @(negedge clk);
    iData = 40'hFF;
    strob = 5'b00001;
    while (WE !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    checks++; if (orbWord !== 12'h7F8) begin errors++; $display("FAIL arst_pre_word: got %h expected 7f8", orbWord); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (WE !== 1'b0)         begin errors++; $display("FAIL arst_we: got %b expected 0", WE); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (orbWord !== 12'h0)   begin errors++; $display("FAIL arst_word: got %h expected 000", orbWord); end
    checks++; if (WrAddr !== 11'h0)    begin errors++; $display("FAIL arst_addr: got %h expected 000", WrAddr); end
    checks++; if (overrun !== 5'h0)    begin errors++; $display("FAIL arst_overrun: got %b expected 00000", overrun); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL arst_frame_done: got %b expected 0", frame_done); end
    checks++; if (swap_ack !== 1'b0)   begin errors++; $display("FAIL arst_swap_ack: got %b expected 0", swap_ack); end
    strob = '0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_simultaneous();
    test_overrun();
    test_swap();
    test_async_reset();
    test_packet_advance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/orb_wr_scheduler.md
ORB_WR_SCHEDULER -- requirements
Module: orb_wr_scheduler

Interface
REQ-001 Parameter NCH, default 5: number of byte channels sharing the frame-buffer write port.
REQ-002 Parameter WPC, default 6: words per channel per packet; NCH*WPC SHALL be at most 32.
REQ-003 Parameter WE_LEN, default 2: WE high width, in clk cycles, 1..15.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 strob  in  NCH  per-channel byte-valid level from the receivers; asynchronous; rising edge = new byte.
REQ-007 iData  in  8*NCH  channel bytes; channel k occupies bits [8k+7:8k]; stable while strob[k] is high.
REQ-008 sw  in  1  frame-buffer page toggle from the reader side; asynchronous.
REQ-009 orbWord  out  12  RAM write data.
REQ-010 WrAddr  out  11  RAM write address.
REQ-011 WE  out  1  RAM write enable.
REQ-012 busy  out  1  high while a write is in progress.
REQ-013 overrun  out  NCH  sticky per-channel data-loss flags.
REQ-014 frame_done  out  1  one-cycle pulse on packet-counter wrap.
REQ-015 swap_ack  out  1  one-cycle pulse after a page toggle is taken.

Function
REQ-016 strob and sw SHALL each pass a 2-FF synchronizer; a byte event is the rising edge of synchronized strob[k].
REQ-017 On a byte event, the channel byte SHALL be latched into a per-channel holding register and pend[k] SHALL be set.
REQ-018 Overrun: an event while pend[k]=1 sets overrun[k] (sticky until reset); the new byte overwrites the held byte.
REQ-019 Full channel: an event while wcnt[k]=WPC sets overrun[k]; the byte is dropped.
REQ-020 FSM states: IDLE, SETUP, WRITE, GAP.
- IDLE->SETUP: any pend[k]=1 and wcnt[k]<WPC.
- SETUP->WRITE: after 1 cycle.
- WRITE->GAP: after WE_LEN cycles.
- GAP->IDLE: after 1 cycle.
REQ-021 Grant: round-robin in IDLE among eligible channels, starting after the last granted channel; after reset, channel 0 has priority.
REQ-022 In SETUP, orbWord SHALL become {1'b0, byte, 3'b000} and WrAddr SHALL become {pack[5:0], k*WPC+wcnt[k]}; pend[k] clears in the same cycle.
REQ-023 WE SHALL be high for exactly the WRITE cycles; orbWord and WrAddr SHALL be stable from SETUP through GAP.
REQ-024 wcnt[k] SHALL increment at WRITE exit.
REQ-025 Packet advance: when every wcnt equals WPC, all wcnt clear and pack increments modulo 64 in the same cycle.
REQ-026 frame_done SHALL pulse on the 63->0 wrap of pack.
REQ-027 busy SHALL be high in SETUP, WRITE and GAP.
REQ-028 A byte event on the same cycle as its own grant SHALL set pend again with the new byte; no overrun is flagged.
REQ-029 Page toggle: a change of synchronized sw SHALL clear pack, all wcnt and all pend, and force the FSM to IDLE.
- An active WE drops on the next cycle; overrun is kept.
- swap_ack pulses one cycle later.
- A toggle has priority over a simultaneous packet advance and byte events.

Reset
REQ-030 While rst=0, the following SHALL be 0:
- orbWord, WrAddr, WE, busy, overrun, frame_done, swap_ack;
- pack, wcnt, pend and the round-robin pointer.
REQ-031 While rst=0, the FSM SHALL be in IDLE.
REQ-032 While rst=0, the sw synchronizer and its old-value register SHALL load 0.
REQ-033 Reset mid-write SHALL drop WE immediately, asynchronously.

Structure
REQ-034 The FSM state encoding and the defaults of NCH, WPC and WE_LEN SHALL live in a shared package, orb_pkg.
REQ-035 The round-robin grant logic SHALL be a sub-module, orb_rr_arb: inputs are the request vector and the pointer; outputs are a one-hot grant and its index.

Verification
REQ-036 Single byte: strob[0] pulse with iData[7:0]=8'hA5 -> one WE pulse of WE_LEN cycles, orbWord=12'h528, WrAddr=0.
REQ-037 Simultaneous events: all 5 strobes at once -> 5 writes in order ch0..ch4, WrAddr 0,6,12,18,24, no overrun.
REQ-038 Overrun: two strob[2] events before its grant -> overrun[2]=1; only the second byte is written.
REQ-039 Packet advance: 6 bytes on every channel -> next write on ch1 has WrAddr=32+6=38; after 64 packets, frame_done pulses once.
REQ-040 Swap mid-write: sw toggled during WRITE -> WE low within 4 cycles of the toggle, then swap_ack; the next write has WrAddr=k*WPC.
REQ-041 Async reset: rst low during WRITE -> WE=0 within the same cycle; all outputs 0.
